// File: rtl/tsmp_pkg.sv
// Shared TSMP definitions: word-type codes, packet-type/subtype codes, default
// ethertype, and the packet-type to TSMP-subtype mapping.
package tsmp_pkg;

    typedef enum logic [1:0] {
        WORD_HEAD = 2'b01,
        WORD_BODY = 2'b11,
        WORD_TAIL = 2'b10
    } word_type_e;

    localparam logic [2:0] PKT_ARP_REQ     = 3'b110;
    localparam logic [2:0] PKT_NMAC_REPORT = 3'b101;
    localparam logic [2:0] PKT_PTP         = 3'b100;

    localparam logic [7:0] SUB_ARP_REQ     = 8'h01;
    localparam logic [7:0] SUB_NMAC_REPORT = 8'h03;
    localparam logic [7:0] SUB_PTP         = 8'h06;

    localparam logic [15:0] TSMP_ETYPE_DEFAULT = 16'hFF01;

    typedef struct packed {
        logic       valid;
        logic [7:0] subtype;
    } subtype_map_t;

    function automatic subtype_map_t map_subtype(input logic [2:0] pkt_type);
        subtype_map_t m;
        m = '0;
        case (pkt_type)
            PKT_ARP_REQ:     m = '{valid: 1'b1, subtype: SUB_ARP_REQ};
            PKT_NMAC_REPORT: m = '{valid: 1'b1, subtype: SUB_NMAC_REPORT};
            PKT_PTP:         m = '{valid: 1'b1, subtype: SUB_PTP};
            default:         m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/frame_encapsulation_module.sv
// Wraps metadata-headed internal frames into TSMP frames for the controller
// port: the metadata head is replaced by a TSMP header, body/tail pass through.
module frame_encapsulation_module
    import tsmp_pkg::*;
#(
    parameter logic [47:0] TSMP_DMAC  = 48'h662211223344,
    parameter logic [47:0] TSMP_SMAC  = 48'h000000000001,
    parameter logic [15:0] TSMP_ETYPE = TSMP_ETYPE_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [133:0] iv_data,
    input  logic         i_data_wr,
    output logic [133:0] ov_data,
    output logic         o_data_wr,
    output logic [15:0]  ov_encap_cnt,
    output logic [15:0]  ov_discard_cnt
);

    typedef enum logic [1:0] {
        IDLE_S,
        TRANS_DATA_S,
        DISCARD_S
    } state_e;

    state_e        state_q, state_d;
    logic [133:0]  ov_data_q, ov_data_d;
    logic          o_data_wr_q, o_data_wr_d;
    logic [15:0]   encap_cnt_q, encap_cnt_d;
    logic [15:0]   discard_cnt_q, discard_cnt_d;

    logic          is_head;
    logic          is_tail;
    subtype_map_t  head_map;

    assign is_head  = i_data_wr && (iv_data[133:132] == WORD_HEAD);
    assign is_tail  = i_data_wr && (iv_data[133:132] == WORD_TAIL);
    assign head_map = map_subtype(iv_data[127:125]);

    always_comb begin
        state_d       = state_q;
        ov_data_d     = '0;
        o_data_wr_d   = 1'b0;
        encap_cnt_d   = encap_cnt_q;
        discard_cnt_d = discard_cnt_q;

        case (state_q)
            IDLE_S: begin
                if (is_head) begin
                    if (head_map.valid) begin
                        ov_data_d   = {WORD_HEAD, 4'b0, TSMP_DMAC, TSMP_SMAC, TSMP_ETYPE,
                                       head_map.subtype, 3'b0, iv_data[124:120]};
                        o_data_wr_d = 1'b1;
                        state_d     = TRANS_DATA_S;
                    end else begin
                        discard_cnt_d = discard_cnt_q + 16'd1;
                        state_d       = DISCARD_S;
                    end
                end
            end

            TRANS_DATA_S: begin
                ov_data_d   = iv_data;
                o_data_wr_d = i_data_wr;
                // A head here means the tail went missing: close the open frame
                // with this word retyped as a tail, and drop the new frame.
                if (is_head) begin
                    ov_data_d     = {WORD_TAIL, 4'b0, iv_data[127:0]};
                    discard_cnt_d = discard_cnt_q + 16'd1;
                    state_d       = DISCARD_S;
                end else if (is_tail) begin
                    encap_cnt_d = encap_cnt_q + 16'd1;
                    state_d     = IDLE_S;
                end
            end

            DISCARD_S: begin
                if (is_tail) begin
                    state_d = IDLE_S;
                end
            end

            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE_S;
            ov_data_q     <= '0;
            o_data_wr_q   <= 1'b0;
            encap_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ov_data_q     <= ov_data_d;
            o_data_wr_q   <= o_data_wr_d;
            encap_cnt_q   <= encap_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign ov_data        = ov_data_q;
    assign o_data_wr      = o_data_wr_q;
    assign ov_encap_cnt   = encap_cnt_q;
    assign ov_discard_cnt = discard_cnt_q;

endmodule

// File: tb/tb_frame_encapsulation_module.sv
// Scoreboard bench for frame_encapsulation_module: directed scenarios plus
// random frame streams checked against a frame-level reference model.
module tb_frame_encapsulation_module;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [133:0] iv_data = '0;
    logic         i_data_wr = 1'b0;
    logic [133:0] ov_data;
    logic         o_data_wr;
    logic [15:0]  ov_encap_cnt;
    logic [15:0]  ov_discard_cnt;

    frame_encapsulation_module #(
        .TSMP_DMAC (48'h662211223344),
        .TSMP_SMAC (48'h000000000001),
        .TSMP_ETYPE(16'hFF01)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .iv_data       (iv_data),
        .i_data_wr     (i_data_wr),
        .ov_data       (ov_data),
        .o_data_wr     (o_data_wr),
        .ov_encap_cnt  (ov_encap_cnt),
        .ov_discard_cnt(ov_discard_cnt)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [133:0] exp_q[$];
    int           mode = 0;      // 0: between frames, 1: forwarding a frame, 2: dropping a frame
    logic [15:0]  m_encap = '0;
    logic [15:0]  m_disc = '0;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [133:0] mk_head(input logic [2:0] ptype, input logic [4:0] port);
        logic [127:0] p;
        p = rnd128();
        p[127:125] = ptype;
        p[124:120] = port;
        return {2'b01, 4'($urandom_range(0, 15)), p};
    endfunction

    function automatic logic [133:0] mk_word(input logic [1:0] wt, input logic [3:0] inv);
        return {wt, inv, rnd128()};
    endfunction

    // Reference: a head opens a frame only for ARP-req/NMAC/PTP and becomes
    // the fixed TSMP header; every other word of an open frame is copied.
    task automatic model(input logic [133:0] w);
        logic [1:0] wt;
        logic [7:0] sub;
        logic       known;
        wt = w[133:132];
        known = 1'b1;
        case (w[127:125])
            3'b110:  sub = 8'h01;
            3'b101:  sub = 8'h03;
            3'b100:  sub = 8'h06;
            default: begin sub = 8'h00; known = 1'b0; end
        endcase
        if (mode == 0) begin
            if (wt == 2'b01) begin
                if (known) begin
                    exp_q.push_back({2'b01, 4'h0, 48'h662211223344, 48'h000000000001,
                                     16'hFF01, sub, 3'b000, w[124:120]});
                    mode = 1;
                end else begin
                    m_disc = m_disc + 16'd1;
                    mode = 2;
                end
            end
        end else if (mode == 1) begin
            if (wt == 2'b01) begin
                exp_q.push_back({2'b10, 4'h0, w[127:0]});
                m_disc = m_disc + 16'd1;
                mode = 2;
            end else begin
                exp_q.push_back(w);
                if (wt == 2'b10) begin
                    m_encap = m_encap + 16'd1;
                    mode = 0;
                end
            end
        end else begin
            if (wt == 2'b10) mode = 0;
        end
    endtask

    task automatic drive(input logic [133:0] w, input logic wr);
        iv_data = w;
        i_data_wr = wr;
        @(posedge clk);
        #1;
        if (wr) model(w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(rnd128(), 1'b0);
    endtask

    task automatic send_frame(input logic [2:0] ptype, input logic [4:0] port,
                              input int nbody, input int gap, input logic with_tail);
        drive(mk_head(ptype, port), 1'b1);
        for (int i = 0; i < nbody; i++) begin
            idle(gap);
            drive(mk_word(2'b11, 4'h0), 1'b1);
        end
        if (with_tail) begin
            idle(gap);
            drive(mk_word(2'b10, 4'($urandom_range(0, 15))), 1'b1);
        end
    endtask

    task automatic check_now(input string name, input logic [133:0] act, input logic [133:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (o_data_wr) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_word: got %h expected no output", ov_data);
                        end else begin
                            logic [133:0] e;
                            e = exp_q.pop_front();
                            if (ov_data !== e) begin
                                errors++;
                                $display("FAIL out_word: got %h expected %h", ov_data, e);
                            end
                        end
                    end
                    if (exp_q.size() != 0) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_word: got o_data_wr=%b expected word %h", o_data_wr, exp_q[0]);
                        exp_q.delete();
                    end
                    check_now("encap_cnt", 134'(ov_encap_cnt), 134'(m_encap));
                    check_now("discard_cnt", 134'(ov_discard_cnt), 134'(m_disc));
                end
            end
        join_none

        #1 rst_n = 1'b0;
        #1;
        check_now("reset_ov_data", ov_data, '0);
        check_now("reset_wr", 134'(o_data_wr), '0);
        check_now("reset_encap", 134'(ov_encap_cnt), '0);
        check_now("reset_discard", 134'(ov_discard_cnt), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // PTP, inport 3, two bodies
        send_frame(3'b100, 5'd3, 2, 0, 1'b1);
        idle(2);
        // ARP, inport 0, head then tail with 2-cycle gaps
        send_frame(3'b110, 5'd0, 0, 2, 1'b1);
        idle(1);
        // Unmapped type followed by NMAC
        drive(mk_head(3'b000, 5'd7), 1'b1);
        drive(mk_word(2'b11, 4'h0), 1'b1);
        drive(mk_word(2'b11, 4'h0), 1'b1);
        drive(mk_word(2'b10, 4'h5), 1'b1);
        send_frame(3'b101, 5'd9, 1, 0, 1'b1);
        idle(1);
        // Missing tail: NMAC head+body, new head truncates, second frame dropped
        send_frame(3'b101, 5'd2, 1, 0, 1'b0);
        send_frame(3'b100, 5'd4, 1, 0, 1'b1);
        send_frame(3'b110, 5'd31, 1, 1, 1'b1);
        // Stray body/tail while idle
        drive(mk_word(2'b11, 4'h0), 1'b1);
        drive(mk_word(2'b10, 4'h3), 1'b1);
        idle(1);

        // Encap counter wrap
        force dut.encap_cnt_q = 16'hFFFF;
        m_encap = 16'hFFFF;
        #1 release dut.encap_cnt_q;
        idle(1);
        send_frame(3'b100, 5'd1, 1, 0, 1'b1);
        idle(1);
        check_now("encap_wrap", 134'(ov_encap_cnt), 134'(16'h0000));

        // Reset mid-body
        send_frame(3'b100, 5'd6, 1, 0, 1'b0);
        iv_data = mk_word(2'b11, 4'h0);
        i_data_wr = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        mode = 0;
        m_encap = '0;
        m_disc = '0;
        check_now("midrst_ov_data", ov_data, '0);
        check_now("midrst_wr", 134'(o_data_wr), '0);
        check_now("midrst_encap", 134'(ov_encap_cnt), '0);
        check_now("midrst_discard", 134'(ov_discard_cnt), '0);
        i_data_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(mk_word(2'b11, 4'h0), 1'b1);
        drive(mk_word(2'b10, 4'h2), 1'b1);
        send_frame(3'b110, 5'd12, 2, 0, 1'b1);
        idle(1);

        // Random frame streams
        for (int f = 0; f < 60; f++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) drive(mk_word(2'b11, 4'h0), 1'b1);
            send_frame(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                       int'($urandom_range(0, 3)), (r < 3) ? int'($urandom_range(1, 2)) : 0,
                       ($urandom_range(0, 7) != 0));
            if (r > 6) idle(int'($urandom_range(1, 3)));
        end
        drive(mk_word(2'b10, 4'h0), 1'b1);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
